// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution and PC redirect/flush controller.
// Optional branch performance counters are enabled by defining BRANCH_CTRL_PERF_CNT_EN.
module branch_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic            br_less_i,
    input  logic            br_equal_i,
    input  logic [XLEN-1:0] target_i,
    output logic            br_unsign_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            excp_misalign_o,
    output logic            illegal_o,
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     br_taken_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            redirect_valid_d, excp_d, illegal_d;
    logic [XLEN-1:0] redirect_pc_d;

    logic            is_cond, legal, cond, taken, accept;
    logic [XLEN-1:0] eff_target;

    assign br_unsign_o = funct3_i[1];

    // jalr > jal > branch: a conditional decode only applies when neither jump flag is set
    always_comb begin
        is_cond    = is_branch_i && !is_jal_i && !is_jalr_i;
        legal      = (funct3_i[2:1] != 2'b01);
        cond       = 1'b0;
        case (funct3_i)
            3'b000:         cond = br_equal_i;
            3'b001:         cond = !br_equal_i;
            3'b100, 3'b110: cond = br_less_i;
            3'b101, 3'b111: cond = !br_less_i;
            default:        cond = 1'b0;
        endcase
        taken      = is_jal_i || is_jalr_i || (legal && cond);
        eff_target = target_i;
        if (is_jalr_i) begin
            eff_target[0] = 1'b0;
        end
        accept = valid_i && !stall_i && (state_q == IDLE)
                 && (is_branch_i || is_jal_i || is_jalr_i);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_o;
        excp_d           = 1'b0;
        illegal_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_cond && !legal) begin
                        illegal_d = 1'b1;
                    end else if (taken) begin
                        if (eff_target[1:0] == 2'b00) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = eff_target;
                            state_d          = FLUSH;
                            cnt_d            = 3'(FLUSH_DEPTH - 1);
                        end else begin
                            excp_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            excp_misalign_o  <= 1'b0;
            illegal_o        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_o <= redirect_valid_d;
            redirect_pc_o    <= redirect_pc_d;
            excp_misalign_o  <= excp_d;
            illegal_o        <= illegal_d;
        end
    end

    assign flush_o = (state_q == FLUSH);

`ifdef BRANCH_CTRL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_o       <= '0;
            br_taken_cnt_o <= '0;
        end else if (accept && is_cond && legal) begin
            br_cnt_o <= br_cnt_o + 32'd1;
            if (cond) begin
                br_taken_cnt_o <= br_taken_cnt_o + 32'd1;
            end
        end
    end
`else
    assign br_cnt_o       = '0;
    assign br_taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, stall_i, is_branch_i, is_jal_i, is_jalr_i;
    logic [2:0]  funct3_i;
    logic        br_less_i, br_equal_i;
    logic [31:0] target_i;
    logic        br_unsign_o, redirect_valid_o, flush_o, excp_misalign_o, illegal_o;
    logic [31:0] redirect_pc_o, br_cnt_o, br_taken_cnt_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    branch_ctrl #(.XLEN(32), .FLUSH_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .funct3_i(funct3_i), .br_less_i(br_less_i), .br_equal_i(br_equal_i),
        .target_i(target_i), .br_unsign_o(br_unsign_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .excp_misalign_o(excp_misalign_o), .illegal_o(illegal_o),
        .br_cnt_o(br_cnt_o), .br_taken_cnt_o(br_taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_in();
        valid_i = 1'b0; is_branch_i = 1'b0; is_jal_i = 1'b0; is_jalr_i = 1'b0;
        funct3_i = 3'b000; br_less_i = 1'b0; br_equal_i = 1'b0; target_i = '0;
    endtask

    // Present one instruction for a single cycle; returns at cycle N+1 (+1ns)
    task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic less, input logic eq, input logic [31:0] tgt);
        valid_i = 1'b1; is_branch_i = br; is_jal_i = jal; is_jalr_i = jalr;
        funct3_i = f3; br_less_i = less; br_equal_i = eq; target_i = tgt;
        tick();
        clear_in();
    endtask

    task automatic outs(input string tag, input logic rv, input logic [31:0] pc, input logic fl,
                        input logic ex, input logic il);
        check({tag, ".redirect_valid"}, 32'(redirect_valid_o), 32'(rv));
        check({tag, ".redirect_pc"},    redirect_pc_o,         pc);
        check({tag, ".flush"},          32'(flush_o),          32'(fl));
        check({tag, ".misalign"},       32'(excp_misalign_o),  32'(ex));
        check({tag, ".illegal"},        32'(illegal_o),        32'(il));
    endtask

    initial begin
        clear_in();
        stall_i = 1'b0;
        rst_i   = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        outs("reset", 0, 32'h0, 0, 0, 0);
        check("reset.br_cnt", br_cnt_o, 32'd0);
        check("reset.br_taken_cnt", br_taken_cnt_o, 32'd0);

        // BEQ taken: redirect at N+1, flush for exactly 2 cycles
        funct3_i = 3'b000; #1;
        check("beq.unsign", 32'(br_unsign_o), 32'd0);
        issue(1, 0, 0, 3'b000, 0, 1, 32'h0000_0100);
        outs("beq.n1", 1, 32'h100, 1, 0, 0);
        tick(); outs("beq.n2", 0, 32'h100, 1, 0, 0);
        tick(); outs("beq.n3", 0, 32'h100, 0, 0, 0);

        // BLTU not taken; unsigned select is combinational
        funct3_i = 3'b110; #1;
        check("bltu.unsign", 32'(br_unsign_o), 32'd1);
        issue(1, 0, 0, 3'b110, 0, 0, 32'h0000_0180);
        outs("bltu.nt", 0, 32'h100, 0, 0, 0);

        // Taken BNE, then a JAL during the flush is squashed
        issue(1, 0, 0, 3'b001, 0, 0, 32'h0000_0200);
        outs("bne.n1", 1, 32'h200, 1, 0, 0);
        issue(0, 1, 0, 3'b000, 0, 0, 32'h0000_0300);
        outs("jal.squash", 0, 32'h200, 1, 0, 0);
        tick(); outs("bne.idle", 0, 32'h200, 0, 0, 0);
        issue(0, 1, 0, 3'b000, 0, 0, 32'h0000_0300);
        outs("jal.after", 1, 32'h300, 1, 0, 0);
        tick(); tick();

        // JALR bit 0 is dropped; bit 1 set still faults
        issue(0, 0, 1, 3'b000, 0, 0, 32'h0000_0203);
        outs("jalr.misalign", 0, 32'h300, 0, 1, 0);
        tick(); outs("jalr.misalign.n2", 0, 32'h300, 0, 0, 0);
        issue(1, 0, 0, 3'b010, 0, 1, 32'h0000_0400);
        outs("illegal", 0, 32'h300, 0, 0, 1);
        tick(); outs("illegal.n2", 0, 32'h300, 0, 0, 0);
        issue(0, 0, 1, 3'b000, 0, 0, 32'h0000_0205);
        outs("jalr.clr0", 1, 32'h204, 1, 0, 0);
        tick(); tick();

        // jalr > jal > branch: branch flags are ignored when a jump flag is set
        issue(1, 1, 1, 3'b000, 0, 0, 32'h0000_0301);
        outs("prio.jalr", 1, 32'h300, 1, 0, 0);
        tick(); tick();

        // Stall holds the flush: 2 + 3 cycles total
        issue(1, 0, 0, 3'b100, 1, 0, 32'h0000_0400);
        outs("stall.n1", 1, 32'h400, 1, 0, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall.flush_held", 32'(flush_o), 32'd1);
        end
        stall_i = 1'b0;
        tick(); check("stall.flush_last", 32'(flush_o), 32'd1);
        tick(); check("stall.flush_drop", 32'(flush_o), 32'd0);

        // Reset mid-flush wins, then an immediate accept proves IDLE
        issue(1, 0, 0, 3'b101, 0, 0, 32'h0000_0500);
        outs("rst.pre", 1, 32'h500, 1, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        outs("rst.mid", 0, 32'h0, 0, 0, 0);
        issue(0, 1, 0, 3'b000, 0, 0, 32'h0000_0600);
        outs("rst.idle", 1, 32'h600, 1, 0, 0);
        tick(); tick();

        // Counter scenario: 3 taken (one misaligned), 2 not taken, 1 JAL, 1 illegal
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        issue(1, 0, 0, 3'b000, 0, 1, 32'h0000_0700); tick(); tick();
        issue(1, 0, 0, 3'b111, 0, 0, 32'h0000_0704); tick(); tick();
        issue(1, 0, 0, 3'b001, 0, 0, 32'h0000_0702);
        check("cnt.misalign", 32'(excp_misalign_o), 32'd1);
        issue(1, 0, 0, 3'b000, 0, 0, 32'h0000_0708);
        issue(1, 0, 0, 3'b100, 0, 0, 32'h0000_070c);
        issue(0, 1, 0, 3'b000, 0, 0, 32'h0000_0710); tick(); tick();
        issue(1, 0, 0, 3'b011, 1, 1, 32'h0000_0714);
`ifdef BRANCH_CTRL_PERF_CNT_EN
        check("perf.br_cnt", br_cnt_o, 32'd5);
        check("perf.br_taken_cnt", br_taken_cnt_o, 32'd3);
`else
        check("perf.br_cnt", br_cnt_o, 32'd0);
        check("perf.br_taken_cnt", br_taken_cnt_o, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
